// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU selection codes, sequencer state encoding and op-class helpers
// for the RV32M multi-cycle execution controller.
package muldiv_sequencer_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  function automatic logic is_m_op(input logic [4:0] sel);
    return (sel >= ALU_MUL) && (sel <= ALU_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [4:0] sel);
    return (sel >= ALU_MUL) && (sel <= ALU_MULHU);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] sel);
    return (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> M-extension sequencer signal bundle.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [4:0]      alu_sel;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, alu_sel, rs1, rs2, flush,
                  input  stall, busy, done, result);
  modport slave  (input  start, alu_sel, rs1, rs2, flush,
                  output stall, busy, done, result);
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring unsigned divider datapath: one quotient bit per step on operand
// magnitudes; sign handling lives in the sequencer.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN:0]      rem_q;
  logic [XLEN-1:0]    quo_q;
  logic [XLEN-1:0]    dvs_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN:0]      rem_sh;
  logic [XLEN:0]      rem_sub;
  logic               take;

  always_comb begin
    rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    take    = (rem_sh >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= take ? rem_sub : rem_sh;
      quo_q <= {quo_q[XLEN-2:0], take};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last      = (cnt_q == CNT_W'(XLEN - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q[XLEN-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execution controller: stalls EX, runs a registered multiply or the
// iterative divider, applies div-by-zero/overflow rules, pulses done.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_sequencer_if.slave md
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t state, nxt;
  logic is_md, mul_op, signed_div, neg_a, neg_b, special;
  logic load, step, clear, last;
  logic [XLEN-1:0] mag_a, mag_b, special_val, quo, rem;
  logic [4:0] op_q;
  logic [XLEN-1:0] a_q, b_q, result_q, result_w, mul_res, div_res;
  logic neg_q_q, neg_r_q, from_div_q;
  logic signed [2*XLEN-1:0] a_ext, b_ext, prod;

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // Issue-cycle decode on the live operands
  always_comb begin
    is_md       = md.start && is_m_op(md.alu_sel);
    mul_op      = is_mul_op(md.alu_sel);
    signed_div  = (md.alu_sel == ALU_DIV) || (md.alu_sel == ALU_REM);
    neg_a       = signed_div && md.rs1[XLEN-1];
    neg_b       = signed_div && md.rs2[XLEN-1];
    mag_a       = cond_neg(neg_a, md.rs1);
    mag_b       = cond_neg(neg_b, md.rs2);
    special     = !mul_op && ((md.rs2 == '0) ||
                  (signed_div && (md.rs1 == MIN_NEG) && (md.rs2 == '1)));
    special_val = '0;
    if (md.rs2 == '0)
      special_val = is_rem_op(md.alu_sel) ? md.rs1 : '1;
    else
      special_val = is_rem_op(md.alu_sel) ? '0 : MIN_NEG;
  end

  always_comb begin
    nxt   = state;
    load  = 1'b0;
    step  = 1'b0;
    clear = 1'b0;
    case (state)
      MD_IDLE: if (is_md) begin
        if (mul_op)       nxt = MD_MUL;
        else if (special) nxt = MD_DONE;
        else begin
          load = 1'b1;
          nxt  = MD_DIV;
        end
      end
      MD_MUL:  nxt = MD_DONE;
      MD_DIV: begin
        step = 1'b1;
        if (last) nxt = MD_DONE;
      end
      MD_DONE: nxt = MD_IDLE;
      default: nxt = MD_IDLE;
    endcase
    if (md.flush) begin
      nxt   = MD_IDLE;
      load  = 1'b0;
      step  = 1'b0;
      clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= nxt;
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .clear    (clear),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quo),
    .remainder(rem),
    .last     (last)
  );

  // Multiply on latched operands; MULHSU treats only rs1 as signed
  always_comb begin
    a_ext   = ((op_q == ALU_MULH) || (op_q == ALU_MULHSU)) ?
              signed'({{XLEN{a_q[XLEN-1]}}, a_q}) : signed'({{XLEN{1'b0}}, a_q});
    b_ext   = (op_q == ALU_MULH) ?
              signed'({{XLEN{b_q[XLEN-1]}}, b_q}) : signed'({{XLEN{1'b0}}, b_q});
    prod    = a_ext * b_ext;
    mul_res = (op_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res = is_rem_op(op_q) ? cond_neg(neg_r_q, rem) : cond_neg(neg_q_q, quo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      from_div_q <= 1'b0;
      result_q   <= '0;
    end else begin
      if ((state == MD_IDLE) && is_md && !md.flush) begin
        op_q       <= md.alu_sel;
        a_q        <= md.rs1;
        b_q        <= md.rs2;
        neg_q_q    <= neg_a ^ neg_b;
        neg_r_q    <= neg_a;
        from_div_q <= !mul_op && !special;
        if (special) result_q <= special_val;
      end
      if ((state == MD_MUL) && !md.flush) result_q <= mul_res;
      if (state == MD_DONE) result_q <= result_w;
    end
  end

  assign result_w  = ((state == MD_DONE) && from_div_q) ? div_res : result_q;
  assign md.result = result_w;
  assign md.done   = (state == MD_DONE);
  assign md.busy   = (state != MD_IDLE);
  assign md.stall  = ((state == MD_IDLE) && is_md) || (state == MD_MUL) || (state == MD_DIV);

endmodule
